conv2_ctrl: RTL and testbench
=============================

Name: conv2_ctrl

Overview:
- Sequencer for a single-MAC sliding-window 2D convolution datapath. Valid-mode, stride 1.
- Walks every output pixel of a SIZE x SIZE image convolved with a SIZEKer x SIZEKer kernel.
- For each pixel, issues the image and kernel read coordinates, drives the MAC clear/enable/last controls, and writes the result to the output buffer with a ready handshake.
- Sits between the top-level start/done interface and the image memory, kernel store, MAC and output buffer.

Parameters:
- SIZE, 640, input image side length in pixels.
- SIZEKer, 3, kernel side length; must satisfy 1 <= SIZEKer <= SIZE.
- CW, $clog2(SIZE) (minimum 1), width of the image and output coordinate ports.
- KW, $clog2(SIZEKer) (minimum 1), width of the kernel coordinate ports.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- img_rd_en  out  1  image and kernel read strobe; read data returns on the next cycle.
- img_row  out  CW  image row = out_row + ker_row.
- img_col  out  CW  image column = out_col + ker_col.
- ker_row  out  KW  kernel tap row.
- ker_col  out  KW  kernel tap column.
- mac_en  out  1  MAC accumulates the current read data.
- mac_clr  out  1  MAC loads the product instead of accumulating; only asserted together with mac_en.
- mac_last  out  1  marks the final tap of the current pixel.
- out_we  out  1  output write request.
- out_ready  in  1  output buffer accepts the write this cycle.
- out_row  out  CW  current output pixel row.
- out_col  out  CW  current output pixel column.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset: state = IDLE. Every output is 0, all counters are 0, and the pipeline bit is cleared. Reset takes effect immediately and aborts any run in progress; no partial write is issued.
- Output grid: N = SIZE - SIZEKer + 1 per side. Pixels are visited in row-major order: out_col is the inner loop, wrapping N-1 -> 0, with out_row incrementing on each wrap.
- Taps are visited in row-major order: ker_col is the inner loop, wrapping SIZEKer-1 -> 0.

State machine:
- IDLE: busy = 0. start = 1 -> RUN with the pixel and tap counters at 0.
- RUN: img_rd_en = 1 every cycle and the tap counter advances every cycle. After tap (SIZEKer-1, SIZEKer-1) -> DRAIN.
- DRAIN: exactly one cycle; no read is issued. -> WRITE.
- WRITE: out_we = 1, with out_row/out_col held stable until out_ready = 1.
  - On accept, if this is the last pixel (N-1, N-1) -> DONE.
  - Otherwise advance the pixel counter -> RUN.
- DONE: done = 1 and busy = 0 for exactly one cycle, then -> IDLE. start is ignored in this state.
- busy = 1 in RUN, DRAIN and WRITE.

MAC pipeline:
- mac_en is img_rd_en delayed by one cycle. mac_clr and mac_last are the first-tap and last-tap flags, each delayed by one cycle.
- mac_clr coincides with the first mac_en of every pixel. mac_last coincides with the last mac_en of a pixel, which falls in the DRAIN cycle.

Timing and boundary rules:
- Cycles per pixel = SIZEKer^2 + 2 when out_ready is held at 1; each cycle of out_ready = 0 adds one cycle.
- start while busy: ignored. No mid-run restart.
- out_ready outside WRITE: ignored.
- No read is issued during DRAIN or WRITE, so backpressure never corrupts the MAC.
- SIZE == SIZEKer: exactly one output pixel at (0, 0).
- Image coordinates never exceed SIZE-1.

Optional Feature:
- Macro: CONV2_CTRL_PERF_EN.
- When defined:
  - Adds output port cycles, 32 bits.
  - Cleared to 0 on reset and when start is accepted.
  - Increments every cycle while busy; saturates at 2^32-1.
  - Holds its value after done until the next accepted start.
- When undefined: the port and the counter do not exist, and all other behaviour is identical.

Test Plan (SIZE = 5, SIZEKer = 3, N = 3; C0 = the cycle in which start is sampled in IDLE):
1. Hold reset, then release with no start -> all outputs stay 0, state remains IDLE, busy = 0 indefinitely.
2. Pulse start with out_ready = 1 throughout:
   - img_rd_en high in C1 through C9, taps (0,0) through (2,2).
   - mac_en high in C2 through C10; mac_clr only in C2; mac_last only in C10.
   - out_we in C11 with out (0,0); the next pixel's RUN starts in C12; pixel period is 11.
   - 9 writes in total; the last write in C99 at (2,2); done pulse in C100.
   - With CONV2_CTRL_PERF_EN defined, cycles = 99 after done.
3. Address check: during pixel (1,2), tap (2,1) -> img_row = 3, img_col = 3.
4. Hold out_ready = 0 for 3 cycles at the first write:
   - out_we is high for 4 cycles with out (0,0) stable.
   - No img_rd_en or mac_en during those cycles.
   - Done moves to C103.
5. Pulse start at C5 and again in the done cycle -> both are ignored and the sequence is unchanged. A start at C101 begins a new run.
6. Assert reset at C6:
   - Outputs drop to 0 asynchronously; no out_we is issued.
   - After release, a fresh start reproduces scenario 2 exactly.
   - With SIZE = SIZEKer = 3, the run produces a single write at (0,0) followed by done.

Source files
------------

// File: rtl/conv2_ctrl.sv
// Sequencer for a single-MAC, stride-1, valid-mode 2D convolution: walks output pixels and kernel taps.
// Optional build macro CONV2_CTRL_PERF_EN adds a saturating 32-bit busy-cycle counter on port "cycles".
module conv2_ctrl #(
    parameter int SIZE    = 640,
    parameter int SIZEKer = 3,
    parameter int CW      = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int KW      = (SIZEKer > 1) ? $clog2(SIZEKer) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          img_rd_en,
    output logic [CW-1:0] img_row,
    output logic [CW-1:0] img_col,
    output logic [KW-1:0] ker_row,
    output logic [KW-1:0] ker_col,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          mac_last,
    output logic          out_we,
    input  logic          out_ready,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          done,
`ifdef CONV2_CTRL_PERF_EN
    output logic [31:0]   cycles,
`endif
    output logic [2:0]    state_dbg
);

    localparam int N = SIZE - SIZEKer + 1;
    localparam logic [CW-1:0] NLAST = CW'(N - 1);
    localparam logic [KW-1:0] KLAST = KW'(SIZEKer - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic tap_clr;
    logic tap_adv;
    logic pix_clr;
    logic pix_adv;
    logic first_tap;
    logic last_tap;
    logic last_pix;

    assign first_tap = (ker_row == '0) && (ker_col == '0);
    assign last_tap  = (ker_row == KLAST) && (ker_col == KLAST);
    assign last_pix  = (out_row == NLAST) && (out_col == NLAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tap_clr    = 1'b0;
        tap_adv    = 1'b0;
        pix_clr    = 1'b0;
        pix_adv    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    tap_clr    = 1'b1;
                    pix_clr    = 1'b1;
                end
            end
            RUN: begin
                tap_adv = 1'b1;
                if (last_tap) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = WRITE;
            end
            WRITE: begin
                // Pixel coordinates stay frozen until the output buffer takes the write.
                if (out_ready) begin
                    if (last_pix) begin
                        state_next = DONE;
                        pix_clr    = 1'b1;
                    end else begin
                        state_next = RUN;
                        pix_adv    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ker_row <= '0;
            ker_col <= '0;
        end else if (tap_clr) begin
            ker_row <= '0;
            ker_col <= '0;
        end else if (tap_adv) begin
            if (ker_col == KLAST) begin
                ker_col <= '0;
                ker_row <= (ker_row == KLAST) ? '0 : ker_row + KW'(1);
            end else begin
                ker_col <= ker_col + KW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_row <= '0;
            out_col <= '0;
        end else if (pix_clr) begin
            out_row <= '0;
            out_col <= '0;
        end else if (pix_adv) begin
            if (out_col == NLAST) begin
                out_col <= '0;
                out_row <= out_row + CW'(1);
            end else begin
                out_col <= out_col + CW'(1);
            end
        end
    end

    // Read data returns one cycle after the strobe, so the MAC controls trail it by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_last <= 1'b0;
        end else begin
            mac_en   <= img_rd_en;
            mac_clr  <= img_rd_en && first_tap;
            mac_last <= img_rd_en && last_tap;
        end
    end

    assign img_rd_en = (state == RUN);
    assign img_row   = out_row + CW'(ker_row);
    assign img_col   = out_col + CW'(ker_col);
    assign out_we    = (state == WRITE);
    assign busy      = (state == RUN) || (state == DRAIN) || (state == WRITE);
    assign done      = (state == DONE);
    assign state_dbg = state;

`ifdef CONV2_CTRL_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else if ((state == IDLE) && start) begin
            cycles <= '0;
        end else if (busy && (cycles != 32'hFFFF_FFFF)) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv2_ctrl.sv
// Bench for conv2_ctrl: vector table on a 5x5/3x3 instance plus randomized runs against a loop-nest model.
module tb_conv2_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // dut0: SIZE=5, SIZEKer=3 ; dut1: SIZE=3, SIZEKer=3
    logic reset0, start0, ready0;
    logic reset1, start1, ready1;
    logic       o0_rd, o0_men, o0_clr, o0_last, o0_we, o0_busy, o0_done;
    logic [2:0] o0_irow, o0_icol, o0_orow, o0_ocol, o0_state;
    logic [1:0] o0_krow, o0_kcol;
    logic       o1_rd, o1_men, o1_clr, o1_last, o1_we, o1_busy, o1_done;
    logic [1:0] o1_irow, o1_icol, o1_orow, o1_ocol;
    logic [2:0] o1_state;
    logic [1:0] o1_krow, o1_kcol;
`ifdef CONV2_CTRL_PERF_EN
    logic [31:0] cyc0, cyc1;
`endif

    conv2_ctrl #(.SIZE(5), .SIZEKer(3)) dut0 (
        .clock(clock), .reset(reset0), .start(start0),
        .img_rd_en(o0_rd), .img_row(o0_irow), .img_col(o0_icol),
        .ker_row(o0_krow), .ker_col(o0_kcol),
        .mac_en(o0_men), .mac_clr(o0_clr), .mac_last(o0_last),
        .out_we(o0_we), .out_ready(ready0), .out_row(o0_orow), .out_col(o0_ocol),
        .busy(o0_busy), .done(o0_done),
`ifdef CONV2_CTRL_PERF_EN
        .cycles(cyc0),
`endif
        .state_dbg(o0_state)
    );

    conv2_ctrl #(.SIZE(3), .SIZEKer(3)) dut1 (
        .clock(clock), .reset(reset1), .start(start1),
        .img_rd_en(o1_rd), .img_row(o1_irow), .img_col(o1_icol),
        .ker_row(o1_krow), .ker_col(o1_kcol),
        .mac_en(o1_men), .mac_clr(o1_clr), .mac_last(o1_last),
        .out_we(o1_we), .out_ready(ready1), .out_row(o1_orow), .out_col(o1_ocol),
        .busy(o1_busy), .done(o1_done),
`ifdef CONV2_CTRL_PERF_EN
        .cycles(cyc1),
`endif
        .state_dbg(o1_state)
    );

    typedef struct packed {
        logic       rd;
        logic       men;
        logic       clr;
        logic       lst;
        logic       we;
        logic       bsy;
        logic       dn;
        logic [2:0] irow;
        logic [2:0] icol;
        logic [1:0] krow;
        logic [1:0] kcol;
        logic [2:0] orow;
        logic [2:0] ocol;
    } obs_t;

    typedef struct {
        int   scen;
        int   cyc;
        obs_t exp;
        bit   full;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[$];
    obs_t cap[0:127];
    bit   ready_pat[0:127];
    bit   start_pat[0:127];
    int   rst_cyc;

    function automatic obs_t mk(bit rd, bit men, bit clr, bit lst, bit we, bit bsy, bit dn,
                                int ir, int ic, int kr, int kc, int orw, int oc);
        obs_t o;
        o.rd = rd; o.men = men; o.clr = clr; o.lst = lst; o.we = we; o.bsy = bsy; o.dn = dn;
        o.irow = 3'(ir); o.icol = 3'(ic); o.krow = 2'(kr); o.kcol = 2'(kc);
        o.orow = 3'(orw); o.ocol = 3'(oc);
        return o;
    endfunction

    function automatic obs_t get_obs(int sel);
        obs_t o;
        if (sel == 0) begin
            o = {o0_rd, o0_men, o0_clr, o0_last, o0_we, o0_busy, o0_done,
                 o0_irow, o0_icol, o0_krow, o0_kcol, o0_orow, o0_ocol};
        end else begin
            o = {o1_rd, o1_men, o1_clr, o1_last, o1_we, o1_busy, o1_done,
                 1'b0, o1_irow, 1'b0, o1_icol, o1_krow, o1_kcol, 1'b0, o1_orow, 1'b0, o1_ocol};
        end
        return o;
    endfunction

    // Coordinates are only meaningful while reading (image/kernel) or writing (output pixel).
    task automatic check_obs(input string name, input obs_t act, input obs_t exp, input bit full);
        obs_t a;
        obs_t e;
        a = act;
        e = exp;
        if (!full && !e.rd) begin
            a.irow = '0; a.icol = '0; a.krow = '0; a.kcol = '0;
            e.irow = '0; e.icol = '0; e.krow = '0; e.kcol = '0;
            if (!e.we) begin
                a.orow = '0; a.ocol = '0;
                e.orow = '0; e.ocol = '0;
            end
        end
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit s, input bit r);
        if (sel == 0) begin
            start0 = s; ready0 = r;
        end else begin
            start1 = s; ready1 = r;
        end
    endtask

    task automatic add(input int scen, input int cyc, input obs_t exp, input bit full);
        vec_t v;
        v.scen = scen; v.cyc = cyc; v.exp = exp; v.full = full;
        tbl.push_back(v);
    endtask

    task automatic clear_pats();
        for (int i = 0; i < 128; i++) begin
            ready_pat[i] = 1'b1;
            start_pat[i] = 1'b0;
        end
        rst_cyc = -10;
    endtask

    // Cycle k=0 is the cycle where start is sampled; cap[k] holds outputs mid-cycle k.
    task automatic capture_run(input int nc);
        @(posedge clock);
        #1 start0 = 1'b1; ready0 = ready_pat[0];
        @(posedge clock);
        for (int k = 1; k <= nc; k++) begin
            #1;
            start0 = start_pat[k];
            ready0 = ready_pat[k];
            if (k == rst_cyc) reset0 = 1'b1;
            if (k == rst_cyc + 2) reset0 = 1'b0;
            @(negedge clock);
            cap[k] = get_obs(0);
            @(posedge clock);
        end
        #1 start0 = 1'b0; ready0 = 1'b1;
    endtask

    task automatic check_scen(input int scen);
        foreach (tbl[i]) begin
            if (tbl[i].scen == scen)
                check_obs($sformatf("s%0d_c%0d", scen, tbl[i].cyc), cap[tbl[i].cyc], tbl[i].exp, tbl[i].full);
        end
    endtask

    task automatic wait_done(input int sel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (get_obs(sel).dn) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_done sel=%0d actual=no_done required=done", sel);
        end
        @(posedge clock);
    endtask

    // Reference: plain loop nest over pixels and taps, DRAIN, WRITE with random backpressure, DONE.
    task automatic model_run(input int sel, input int n, input int k, input int ready_pct);
        bit p_rd, p_first, p_last, rdy;
        int busy_cnt, stalls;
        p_rd = 0; p_first = 0; p_last = 0; busy_cnt = 0;
        @(posedge clock);
        #1 drive(sel, 1'b1, 1'b1);
        @(posedge clock);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                for (int t = 0; t < k * k; t++) begin
                    #1 drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    @(negedge clock);
                    check_obs($sformatf("m%0d_px%0d_%0d_t%0d", sel, r, c, t), get_obs(sel),
                              mk(1, p_rd, p_first, p_last, 0, 1, 0, r + t / k, c + t % k, t / k, t % k, r, c), 0);
                    p_rd = 1; p_first = (t == 0); p_last = (t == k * k - 1);
                    busy_cnt++;
                    @(posedge clock);
                end
                #1 drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                @(negedge clock);
                check_obs($sformatf("m%0d_drain%0d_%0d", sel, r, c), get_obs(sel),
                          mk(0, 1, p_first, 1, 0, 1, 0, 0, 0, 0, 0, r, c), 0);
                busy_cnt++;
                @(posedge clock);
                stalls = 0;
                rdy = 0;
                while (!rdy) begin
                    rdy = (stalls >= 4) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
                    #1 drive(sel, 1'($urandom_range(0, 1)), rdy);
                    @(negedge clock);
                    check_obs($sformatf("m%0d_wr%0d_%0d_s%0d", sel, r, c, stalls), get_obs(sel),
                              mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, r, c), 0);
                    busy_cnt++;
                    stalls++;
                    @(posedge clock);
                end
                p_rd = 0; p_first = 0; p_last = 0;
            end
        end
        #1 drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clock);
        check_obs($sformatf("m%0d_done", sel), get_obs(sel), mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
`ifdef CONV2_CTRL_PERF_EN
        check_int($sformatf("m%0d_cycles", sel), (sel == 0) ? cyc0 : cyc1, busy_cnt);
`endif
        @(posedge clock);
        #1 drive(sel, 1'b0, 1'b1);
        @(negedge clock);
        check_obs($sformatf("m%0d_idle", sel), get_obs(sel), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scenario 2: free-running output buffer
        add(2, 1,   mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        add(2, 2,   mk(1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0), 0);
        add(2, 3,   mk(1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 2, 0, 0), 0);
        add(2, 9,   mk(1, 1, 0, 0, 0, 1, 0, 2, 2, 2, 2, 0, 0), 0);
        add(2, 10,  mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        add(2, 11,  mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        add(2, 12,  mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1), 0);
        add(2, 13,  mk(1, 1, 1, 0, 0, 1, 0, 0, 2, 0, 1, 0, 1), 0);
        add(2, 63,  mk(1, 1, 0, 0, 0, 1, 0, 3, 3, 2, 1, 1, 2), 0);
        add(2, 99,  mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 2), 0);
        add(2, 100, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        add(2, 101, z, 0);
        // Scenario 4: three stalled cycles on the first write
        add(4, 10,  mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        for (int c = 11; c <= 14; c++) add(4, c, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        add(4, 15,  mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1), 0);
        add(4, 16,  mk(1, 1, 1, 0, 0, 1, 0, 0, 2, 0, 1, 0, 1), 0);
        add(4, 102, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 2), 0);
        add(4, 103, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        add(4, 104, z, 0);
        // Scenario 5: start while busy and in the done cycle is ignored; start at C101 restarts
        add(5, 6,   mk(1, 1, 0, 0, 0, 1, 0, 1, 2, 1, 2, 0, 0), 0);
        add(5, 11,  mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        add(5, 99,  mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 2), 0);
        add(5, 100, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0);
        add(5, 101, z, 0);
        add(5, 102, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0);
        // Scenario 6: reset asserted in C6, released in C8
        add(6, 5,   mk(1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0), 0);
        for (int c = 6; c <= 10; c++) add(6, c, z, 1);

        // Scenario 1: reset, then idle with no start
        reset0 = 1'b1; reset1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_obs("rst_hold0", get_obs(0), z, 1);
            check_obs("rst_hold1", get_obs(1), z, 1);
        end
        @(posedge clock);
        #1 reset0 = 1'b0; reset1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_obs("idle0", get_obs(0), z, 1);
            check_obs("idle1", get_obs(1), z, 1);
        end

        clear_pats();
        capture_run(101);
        check_scen(2);
`ifdef CONV2_CTRL_PERF_EN
        check_int("s2_cycles", cyc0, 99);
`endif

        clear_pats();
        ready_pat[11] = 1'b0; ready_pat[12] = 1'b0; ready_pat[13] = 1'b0;
        capture_run(104);
        check_scen(4);

        clear_pats();
        start_pat[5] = 1'b1; start_pat[100] = 1'b1; start_pat[101] = 1'b1;
        capture_run(102);
        check_scen(5);
        wait_done(0, 300);

        clear_pats();
        rst_cyc = 6;
        capture_run(10);
        check_scen(6);
        clear_pats();
        capture_run(101);
        check_scen(2);

        model_run(1, 1, 3, 100);
        model_run(0, 3, 3, 60);
        model_run(1, 1, 3, 40);
        model_run(0, 3, 3, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
